// File: rtl/param_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : param_load_sequencer_if
// Brief   : Control-bus write port (plus optional readback) of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface param_load_sequencer_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
`ifdef PARAM_READBACK_EN
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr,
                  input  wr_err, rd_data, rd_valid);
  modport slave  (input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
                  output wr_err, rd_data, rd_valid);
`else
  modport master (output wr_en, wr_addr, wr_data, input wr_err);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_err);
`endif
endinterface
`default_nettype wire

// File: rtl/param_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : param_load_sequencer
// Brief   : Shadow-register writes, then a commit that presents a coherent
//           parameter set with guaranteed setup/hold/gap around load_param.
//           Optional readback port guarded by PARAM_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module param_load_sequencer #(
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  param_load_sequencer_if.slave   wr_bus,
  output logic                    busy,
  output logic [15:0]             cmos_freq,
  output logic [15:0]             cmos_width,
  output logic [31:0]             laser_freq,
  output logic [31:0]             laser_width,
  output logic [31:0]             frame_gate_width_a,
  output logic [31:0]             frame_gate_delay_a,
  output logic [31:0]             frame_gate_width_b,
  output logic [31:0]             frame_gate_delay_b,
  output logic [7:0]              tim_cycles_m,
  output logic [7:0]              delay_step_delta_t,
  output logic [15:0]             bg_frame_deci_n,
  output logic                    load_param,
  output logic                    commit_done
);

  localparam logic [7:0] C_SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] C_HOLD_LOAD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] C_GAP_LOAD    = 8'(GAP_CYC - 1);
  localparam logic [3:0] C_ADDR_LAST   = 4'hA;
  localparam logic [3:0] C_ADDR_COMMIT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_pending;
  logic        r_busy;
  logic        r_load_param;
  logic        r_commit_done;
  logic        r_wr_err;

  logic [15:0] r_sh_cmos_freq, r_sh_cmos_width, r_sh_bg_frame_deci_n;
  logic [31:0] r_sh_laser_freq, r_sh_laser_width;
  logic [31:0] r_sh_fg_width_a, r_sh_fg_delay_a, r_sh_fg_width_b, r_sh_fg_delay_b;
  logic [7:0]  r_sh_tim_cycles_m, r_sh_delay_step_delta_t;

  logic [15:0] r_cmos_freq, r_cmos_width, r_bg_frame_deci_n;
  logic [31:0] r_laser_freq, r_laser_width;
  logic [31:0] r_fg_width_a, r_fg_delay_a, r_fg_width_b, r_fg_delay_b;
  logic [7:0]  r_tim_cycles_m, r_delay_step_delta_t;

  logic        w_commit;
  logic        w_unmapped;

  assign w_commit   = wr_bus.wr_en && (wr_bus.wr_addr == C_ADDR_COMMIT);
  assign w_unmapped = wr_bus.wr_en && (wr_bus.wr_addr > C_ADDR_LAST) &&
                      (wr_bus.wr_addr != C_ADDR_COMMIT);

  // Shadow bank: narrow fields keep the low bits of the bus word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_cmos_freq          <= '0;
      r_sh_cmos_width         <= '0;
      r_sh_laser_freq         <= '0;
      r_sh_laser_width        <= '0;
      r_sh_fg_width_a         <= '0;
      r_sh_fg_delay_a         <= '0;
      r_sh_fg_width_b         <= '0;
      r_sh_fg_delay_b         <= '0;
      r_sh_tim_cycles_m       <= '0;
      r_sh_delay_step_delta_t <= '0;
      r_sh_bg_frame_deci_n    <= '0;
      r_wr_err                <= 1'b0;
    end else begin
      r_wr_err <= w_unmapped;
      if (wr_bus.wr_en) begin
        case (wr_bus.wr_addr)
          4'h0: r_sh_cmos_freq          <= wr_bus.wr_data[15:0];
          4'h1: r_sh_cmos_width         <= wr_bus.wr_data[15:0];
          4'h2: r_sh_laser_freq         <= wr_bus.wr_data;
          4'h3: r_sh_laser_width        <= wr_bus.wr_data;
          4'h4: r_sh_fg_width_a         <= wr_bus.wr_data;
          4'h5: r_sh_fg_delay_a         <= wr_bus.wr_data;
          4'h6: r_sh_fg_width_b         <= wr_bus.wr_data;
          4'h7: r_sh_fg_delay_b         <= wr_bus.wr_data;
          4'h8: r_sh_tim_cycles_m       <= wr_bus.wr_data[7:0];
          4'h9: r_sh_delay_step_delta_t <= wr_bus.wr_data[7:0];
          4'hA: r_sh_bg_frame_deci_n    <= wr_bus.wr_data[15:0];
          default: ;
        endcase
      end
    end
  end

  // Sequencer; the output bank only loads on the IDLE->SETUP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= ST_IDLE;
      r_cnt                <= '0;
      r_pending            <= 1'b0;
      r_busy               <= 1'b0;
      r_load_param         <= 1'b0;
      r_commit_done        <= 1'b0;
      r_cmos_freq          <= '0;
      r_cmos_width         <= '0;
      r_laser_freq         <= '0;
      r_laser_width        <= '0;
      r_fg_width_a         <= '0;
      r_fg_delay_a         <= '0;
      r_fg_width_b         <= '0;
      r_fg_delay_b         <= '0;
      r_tim_cycles_m       <= '0;
      r_delay_step_delta_t <= '0;
      r_bg_frame_deci_n    <= '0;
    end else begin
      r_commit_done <= 1'b0;
      if (w_commit && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_commit || r_pending) begin
            r_cmos_freq          <= r_sh_cmos_freq;
            r_cmos_width         <= r_sh_cmos_width;
            r_laser_freq         <= r_sh_laser_freq;
            r_laser_width        <= r_sh_laser_width;
            r_fg_width_a         <= r_sh_fg_width_a;
            r_fg_delay_a         <= r_sh_fg_delay_a;
            r_fg_width_b         <= r_sh_fg_width_b;
            r_fg_delay_b         <= r_sh_fg_delay_b;
            r_tim_cycles_m       <= r_sh_tim_cycles_m;
            r_delay_step_delta_t <= r_sh_delay_step_delta_t;
            r_bg_frame_deci_n    <= r_sh_bg_frame_deci_n;
            r_cnt                <= C_SETUP_LOAD;
            r_pending            <= 1'b0;
            r_busy               <= 1'b1;
            r_state              <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_cnt        <= C_HOLD_LOAD;
            r_load_param <= 1'b1;
            r_state      <= ST_PULSE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == 8'd0) begin
            r_cnt        <= C_GAP_LOAD;
            r_load_param <= 1'b0;
            r_state      <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == 8'd0) begin
            r_commit_done <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_load_param <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PARAM_READBACK_EN
  logic [31:0] w_rd_mux;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  always_comb begin
    w_rd_mux = '0;
    case (wr_bus.rd_addr)
      4'h0: w_rd_mux = {16'd0, r_sh_cmos_freq};
      4'h1: w_rd_mux = {16'd0, r_sh_cmos_width};
      4'h2: w_rd_mux = r_sh_laser_freq;
      4'h3: w_rd_mux = r_sh_laser_width;
      4'h4: w_rd_mux = r_sh_fg_width_a;
      4'h5: w_rd_mux = r_sh_fg_delay_a;
      4'h6: w_rd_mux = r_sh_fg_width_b;
      4'h7: w_rd_mux = r_sh_fg_delay_b;
      4'h8: w_rd_mux = {24'd0, r_sh_tim_cycles_m};
      4'h9: w_rd_mux = {24'd0, r_sh_delay_step_delta_t};
      4'hA: w_rd_mux = {16'd0, r_sh_bg_frame_deci_n};
      4'hF: w_rd_mux = {31'd0, r_busy};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= wr_bus.rd_en;
      if (wr_bus.rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign wr_bus.rd_data  = r_rd_data;
  assign wr_bus.rd_valid = r_rd_valid;
`else
  // Write-only build: no readback path.
`endif

  assign wr_bus.wr_err      = r_wr_err;
  assign busy               = r_busy;
  assign load_param         = r_load_param;
  assign commit_done        = r_commit_done;
  assign cmos_freq          = r_cmos_freq;
  assign cmos_width         = r_cmos_width;
  assign laser_freq         = r_laser_freq;
  assign laser_width        = r_laser_width;
  assign frame_gate_width_a = r_fg_width_a;
  assign frame_gate_delay_a = r_fg_delay_a;
  assign frame_gate_width_b = r_fg_width_b;
  assign frame_gate_delay_b = r_fg_delay_b;
  assign tim_cycles_m       = r_tim_cycles_m;
  assign delay_step_delta_t = r_delay_step_delta_t;
  assign bg_frame_deci_n    = r_bg_frame_deci_n;

endmodule
`default_nettype wire

// File: tb/tb_param_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_param_load_sequencer
// Brief   : Directed + random stimulus against a window-level reference model,
//           with a load_param scoreboard and per-cycle output monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_param_load_sequencer;
  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 8;
  localparam int WIN   = SETUP + HOLD + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_load_sequencer_if bus ();

  logic        busy, load_param, commit_done;
  logic [15:0] cmos_freq, cmos_width, bg_frame_deci_n;
  logic [31:0] laser_freq, laser_width;
  logic [31:0] frame_gate_width_a, frame_gate_delay_a, frame_gate_width_b, frame_gate_delay_b;
  logic [7:0]  tim_cycles_m, delay_step_delta_t;

  param_load_sequencer #(.SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_bus(bus), .busy(busy),
    .cmos_freq(cmos_freq), .cmos_width(cmos_width),
    .laser_freq(laser_freq), .laser_width(laser_width),
    .frame_gate_width_a(frame_gate_width_a), .frame_gate_delay_a(frame_gate_delay_a),
    .frame_gate_width_b(frame_gate_width_b), .frame_gate_delay_b(frame_gate_delay_b),
    .tim_cycles_m(tim_cycles_m), .delay_step_delta_t(delay_step_delta_t),
    .bg_frame_deci_n(bg_frame_deci_n), .load_param(load_param), .commit_done(commit_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           rise;
    logic [255:0] vals;
  } exp_t;
  exp_t sb[$];
  exp_t e_new, e_pop;

  // Reference model: register file, a busy window counted down in cycles, pending flag.
  logic [31:0] sh   [16];
  logic [31:0] outv [16];
  int  left    = 0;
  int  edge_n  = 0;
  bit  pend    = 0;
  bit  exp_err = 0, exp_done = 0, exp_load = 0;
  bit  commit;
`ifdef PARAM_READBACK_EN
  bit          exp_rd_valid = 0;
  logic [31:0] exp_rd_data  = '0;
`endif

  initial for (int i = 0; i < 16; i++) begin sh[i] = '0; outv[i] = '0; end

  function automatic logic [31:0] field_mask(input logic [3:0] a);
    case (a)
      4'h0, 4'h1, 4'hA: return 32'h0000_FFFF;
      4'h8, 4'h9:       return 32'h0000_00FF;
      default:          return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [255:0] pack_model();
    return {outv[0][15:0], outv[1][15:0], outv[2], outv[3], outv[4], outv[5],
            outv[6], outv[7], outv[8][7:0], outv[9][7:0], outv[10][15:0]};
  endfunction

  function automatic logic [255:0] pack_dut();
    return {cmos_freq, cmos_width, laser_freq, laser_width, frame_gate_width_a,
            frame_gate_delay_a, frame_gate_width_b, frame_gate_delay_b,
            tim_cycles_m, delay_step_delta_t, bg_frame_deci_n};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin sh[i] = '0; outv[i] = '0; end
      left = 0; pend = 0; exp_err = 0; exp_done = 0; exp_load = 0;
`ifdef PARAM_READBACK_EN
      exp_rd_valid = 0; exp_rd_data = '0;
`endif
      sb.delete();
    end else begin
      edge_n++;
`ifdef PARAM_READBACK_EN
      exp_rd_valid = bus.rd_en;
      if (bus.rd_en)
        exp_rd_data = (bus.rd_addr == 4'hF) ? {31'd0, left != 0} :
                      (bus.rd_addr <= 4'hA) ? sh[bus.rd_addr] : 32'd0;
`endif
      exp_err  = bus.wr_en && (bus.wr_addr >= 4'hB) && (bus.wr_addr <= 4'hE);
      exp_done = 0;
      commit   = bus.wr_en && (bus.wr_addr == 4'hF);
      if (left == 0) begin
        if (commit || pend) begin
          outv = sh;
          left = WIN;
          pend = 0;
          e_new.rise = edge_n + SETUP;
          e_new.vals = pack_model();
          sb.push_back(e_new);
        end
      end else begin
        if (commit) pend = 1;
        left--;
        if (left == 0) exp_done = 1;
      end
      exp_load = (left != 0) && (WIN - left >= SETUP) && (WIN - left < SETUP + HOLD);
      if (bus.wr_en && bus.wr_addr <= 4'hA)
        sh[bus.wr_addr] = bus.wr_data & field_mask(bus.wr_addr);
    end
  end

  // Monitor: per-cycle comparisons plus scoreboard pop on each load_param rise.
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, left != 0);
      chk("load_param", load_param, exp_load);
      chk("wr_err", bus.wr_err, exp_err);
      chk("commit_done", commit_done, exp_done);
      chk("outputs", pack_dut(), pack_model());
`ifdef PARAM_READBACK_EN
      chk("rd_valid", bus.rd_valid, exp_rd_valid);
      if (exp_rd_valid) chk("rd_data", bus.rd_data, exp_rd_data);
`endif
      if (load_param && !prev_load) begin
        if (sb.size() == 0) begin
          chk("unexpected_load_rise", 1, 0);
        end else begin
          e_pop = sb.pop_front();
          chk("load_rise_cycle", e_pop.rise, edge_n);
          chk("load_rise_params", pack_dut(), e_pop.vals);
        end
      end
      prev_load = load_param;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef PARAM_READBACK_EN
    bus.rd_en = 1'b0; bus.rd_addr = '0;
`endif
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    wr(4'h2, 32'h0000_1388); wr(4'h0, 32'h0000_03E8); wr(4'hF, 32'd0);
    idle(20);
    chk("laser_freq_5000", laser_freq, 32'd5000);
    chk("cmos_freq_1000", cmos_freq, 16'd1000);

    wr(4'h1, 32'hFFFF_1234); wr(4'hF, $urandom);
    idle(20);
    chk("cmos_width_trunc", cmos_width, 16'h1234);

    // Write and commit while pulsing: second sequence picks up 77.
    wr(4'hF, 32'd0); idle(5); wr(4'h4, 32'd77); wr(4'hF, 32'd0);
    idle(40);
    chk("fg_width_a_77", frame_gate_width_a, 32'd77);

    wr(4'hF, 32'd0); idle(2); wr(4'hF, 32'd0); idle(3); wr(4'hF, 32'd0);
    idle(40);

    wr(4'hC, 32'hDEAD_BEEF);
    idle(3);

    // Reset in the middle of the pulse.
    wr(4'h9, 32'h0000_00AB); wr(4'hF, 32'd0);
    idle(6);
    chk("pulse_before_reset", load_param, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_load_param", load_param, 0);
    chk("reset_busy", busy, 0);
    chk("reset_outputs", pack_dut(), 256'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    wr(4'hF, 32'd0);
    idle(20);
    chk("post_reset_outputs", pack_dut(), 256'd0);

    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
`ifdef PARAM_READBACK_EN
      bus.rd_en   = ($urandom_range(0, 3) == 0);
      bus.rd_addr = 4'($urandom_range(0, 15));
`endif
      if (r < 6) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'hF; bus.wr_data = $urandom;
      end else if (r < 45) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'($urandom_range(0, 15)); bus.wr_data = $urandom;
      end else begin
        bus.wr_en = 1'b0;
      end
      idle(1);
    end
    bus.wr_en = 1'b0;
`ifdef PARAM_READBACK_EN
    bus.rd_en = 1'b0;
`endif

    for (int i = 0; i < 300 && (left != 0 || pend); i++) idle(1);
    idle(3);
    chk("drain_idle", (left == 0 && !pend), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/param_load_sequencer.md
Name: param_load_sequencer

Overview:
- Transmit side of the timing-generator parameter interface.
- Accepts register-style word writes from the control bus (AXI-lite slave decode upstream) into shadow registers.
- On a commit write, it presents a stable parameter set and then raises load_param with guaranteed setup, hold and recovery.
- The downstream parameter-check stage, which latches on the load_param rising edge, therefore always captures a coherent set.

Parameters:
- SETUP_CYC, 4: cycles outputs are stable before load_param rises (1..255).
- HOLD_CYC, 4: cycles load_param stays high (1..255).
- GAP_CYC, 8: cycles load_param stays low after a pulse before another may start (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one word per cycle
- wr_addr  in  4  word address
- wr_data  in  32  write data
- wr_err  out  1  one-cycle pulse: write to unmapped address
- busy  out  1  high in any state other than IDLE
- cmos_freq, cmos_width  out  16 each  parameter outputs
- laser_freq, laser_width  out  32 each
- frame_gate_width_a, frame_gate_delay_a, frame_gate_width_b, frame_gate_delay_b  out  32 each
- tim_cycles_m, delay_step_delta_t  out  8 each
- bg_frame_deci_n  out  16
- load_param  out  1  load strobe (level pulse, HOLD_CYC wide)
- commit_done  out  1  one-cycle pulse at end of GAP

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release.
  - All shadow and output registers 0; load_param, busy, wr_err, commit_done 0; FSM in IDLE; pending 0.
  - Reset mid-pulse drops load_param immediately.
- Address map: 0 cmos_freq, 1 cmos_width, 2 laser_freq, 3 laser_width, 4 fg_width_a, 5 fg_delay_a, 6 fg_width_b, 7 fg_delay_b, 8 tim_cycles_m, 9 delay_step_delta_t, A bg_frame_deci_n, F commit (data ignored).
- Narrow fields take wr_data LSBs; upper bits are discarded.
- Addresses B..E: no state change; wr_err pulses the next cycle.
- Shadow writes are accepted in every state and take effect the cycle after wr_en. They never alter the outputs directly. No range clamping here; the receiver clamps.
- FSM (single counter cnt, 8 bit):
  - IDLE: on commit (or pending set), copy all shadow to outputs in the same clock edge, cnt<=SETUP_CYC-1, go SETUP, clear pending.
  - SETUP: load_param 0; cnt decrements; at cnt==0 go PULSE, cnt<=HOLD_CYC-1.
  - PULSE: load_param 1; at cnt==0 go GAP, cnt<=GAP_CYC-1.
  - GAP: load_param 0; at cnt==0 pulse commit_done and go IDLE.
- Outputs change only on the IDLE->SETUP edge. They are constant from that edge through the end of GAP.
- load_param is registered.
  - Latency from the commit write (wr_en cycle) to load_param rising: SETUP_CYC+1 cycles.
  - Total busy window: SETUP_CYC+HOLD_CYC+GAP_CYC cycles.
- Commit while busy: set pending (multiple commits collapse to one). On return to IDLE, the next sequence starts the following cycle with the shadow contents at that time.
- Shadow write and commit in the same cycle is impossible (single port). A write in the cycle immediately before commit is included in the copy.

Optional Feature:
- PARAM_READBACK_EN defined: adds ports rd_en in 1, rd_addr in 4, rd_data out 32, rd_valid out 1.
  - rd_data returns the zero-extended shadow value with 1-cycle latency; rd_valid pulses with it.
  - Address F reads {31'b0, busy}; unmapped addresses read 0.
  - Reset values: rd_data 0, rd_valid 0.
- Undefined: these ports are absent and no readback logic is built.

Test Plan:
- Reset then write addr2=0x0000_1388, addr0=0x0000_03E8, commit -> load_param rises exactly 5 cycles after the commit wr_en, stays high 4 cycles; laser_freq=5000 and cmos_freq=1000 stable from cycle 1 to commit_done; busy high 16 cycles.
- Write addr1=0xFFFF_1234 -> after commit, cmos_width=0x1234.
- During PULSE, write addr4=77 and commit -> first sequence outputs are unchanged; a second sequence starts 1 cycle after the first commit_done with frame_gate_width_a=77; exactly two load_param pulses.
- Three commits during one busy window -> exactly one extra sequence.
- Write addr 0xC -> wr_err pulses once, no output or shadow change.
- Assert rst_n low during PULSE -> load_param, busy and outputs 0 immediately; after release, commit reproduces the reset-value sequence.
